// File: rtl/clock_set_controller.sv
// clock_set_controller: button-driven time-set sequencer for the binary clock.
// Debounces SELECT/INC, steps RUN->HOUR->MIN->SEC->RUN and issues increment pulses with auto-repeat.

module clock_set_controller #(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int BLINK_HALF    = 25_000_000,
  parameter int TIMEOUT       = 1_000_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_select,
  input  logic       btn_inc,
  output logic       set_mode,
  output logic [1:0] sel_field,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       blink,
  output logic [3:0] mode_at
);

  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int BLINK_W  = $clog2(BLINK_HALF + 1);
  localparam int IDLE_W   = $clog2(TIMEOUT + 1);

  // Encoding doubles as the sel_field code.
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HOUR = 2'b01,
    ST_MIN  = 2'b10,
    ST_SEC  = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_sync1;
  logic [1:0]         r_sync2;
  logic [1:0]         r_level;
  logic [1:0]         r_level_d;
  logic [DEB_W-1:0]   r_deb_cnt [2];
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic               r_rep_active;
  logic               r_rep_first;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink;
  logic [IDLE_W-1:0]  r_idle;
  logic               r_inc_hour;
  logic               r_inc_min;
  logic               r_inc_sec;

  logic w_sel_evt;
  logic w_inc_evt;
  logic w_inc_level;
  logic w_timeout;
  logic w_stay;
  logic w_press_ok;
  logic w_rep_fire;
  logic w_pulse;
  logic w_enter_set;
  logic w_clear_idle;

  // Bit 0 is SELECT, bit 1 is INC: 2-flop synchroniser then stable-count debouncer.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_sync1   <= 2'b00;
      r_sync2   <= 2'b00;
      r_level   <= 2'b00;
      r_level_d <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        r_deb_cnt[b] <= '0;
      end
    end else begin
      r_sync1   <= {btn_inc, btn_select};
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_level[b]) begin
          r_deb_cnt[b] <= '0;
        end else if (r_deb_cnt[b] == DEB_W'(DEB_CYCLES - 1)) begin
          r_level[b]   <= r_sync2[b];
          r_deb_cnt[b] <= '0;
        end else begin
          r_deb_cnt[b] <= r_deb_cnt[b] + DEB_W'(1);
        end
      end
    end
  end

  assign w_sel_evt   = r_level[0] & ~r_level_d[0];
  assign w_inc_evt   = r_level[1] & ~r_level_d[1];
  assign w_inc_level = r_level[1];
  assign w_timeout   = (r_state != ST_RUN) && (r_idle == IDLE_W'(TIMEOUT));

  // Next state plus pulse qualification; SELECT and timeout both pre-empt INC.
  always_comb begin
    w_next     = r_state;
    w_stay     = 1'b0;
    w_press_ok = 1'b0;
    w_rep_fire = 1'b0;
    case (r_state)
      ST_RUN:  if (w_sel_evt) w_next = ST_HOUR; else w_next = ST_RUN;
      ST_HOUR: if (w_sel_evt) w_next = ST_MIN;  else if (w_timeout) w_next = ST_RUN; else w_next = ST_HOUR;
      ST_MIN:  if (w_sel_evt) w_next = ST_SEC;  else if (w_timeout) w_next = ST_RUN; else w_next = ST_MIN;
      ST_SEC:  if (w_sel_evt) w_next = ST_RUN;  else if (w_timeout) w_next = ST_RUN; else w_next = ST_SEC;
      default: w_next = ST_RUN;
    endcase
    w_stay     = (r_state != ST_RUN) && (w_next == r_state);
    w_press_ok = w_stay && w_inc_evt;
    if (r_rep_first) begin
      w_rep_fire = w_stay && r_rep_active && w_inc_level && (r_hold_cnt == HOLD_W'(REPEAT_DELAY - 1));
    end else begin
      w_rep_fire = w_stay && r_rep_active && w_inc_level && (r_hold_cnt == HOLD_W'(REPEAT_PERIOD - 1));
    end
  end

  assign w_pulse      = w_press_ok | w_rep_fire;
  assign w_enter_set  = (w_next != ST_RUN) && (w_next != r_state);
  assign w_clear_idle = w_sel_evt | w_inc_evt | w_rep_fire | (w_next != r_state);

  // State register.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Auto-repeat hold counter; leaving the field or releasing INC cancels the repeat.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_rep_active <= 1'b0;
      r_rep_first  <= 1'b0;
      r_hold_cnt   <= '0;
    end else if (w_press_ok) begin
      r_rep_active <= 1'b1;
      r_rep_first  <= 1'b1;
      r_hold_cnt   <= '0;
    end else if (!w_stay || !w_inc_level) begin
      r_rep_active <= 1'b0;
      r_hold_cnt   <= '0;
    end else if (w_rep_fire) begin
      r_rep_first <= 1'b0;
      r_hold_cnt  <= '0;
    end else if (r_rep_active && (r_hold_cnt != HOLD_W'(HOLD_MAX))) begin
      r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    end
  end

  // Registered increment pulses, routed to the field being edited.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_inc_hour <= 1'b0;
      r_inc_min  <= 1'b0;
      r_inc_sec  <= 1'b0;
    end else begin
      r_inc_hour <= w_pulse && (r_state == ST_HOUR);
      r_inc_min  <= w_pulse && (r_state == ST_MIN);
      r_inc_sec  <= w_pulse && (r_state == ST_SEC);
    end
  end

  // Blink generator, restarted visible on field entry and on every increment.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (w_next == ST_RUN) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (w_enter_set || w_pulse) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
      r_blink     <= ~r_blink;
      r_blink_cnt <= '0;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  // Saturating idle counter for the forced return to RUN.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_idle <= '0;
    end else if ((r_state == ST_RUN) || w_clear_idle) begin
      r_idle <= '0;
    end else if (r_idle != IDLE_W'(TIMEOUT)) begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end

  assign set_mode  = (r_state != ST_RUN);
  assign sel_field = r_state;
  assign mode_at   = (r_state == ST_RUN) ? 4'hB : 4'hC;
  assign blink     = r_blink;
  assign inc_hour  = r_inc_hour;
  assign inc_min   = r_inc_min;
  assign inc_sec   = r_inc_sec;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with shortened timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_clock_set_controller;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic       btn_select = 1'b0;
  logic       btn_inc    = 1'b0;
  logic       set_mode;
  logic [1:0] sel_field;
  logic       inc_hour;
  logic       inc_min;
  logic       inc_sec;
  logic       blink;
  logic [3:0] mode_at;

  int total = 0;
  int bad   = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  clock_set_controller #(
    .DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .BLINK_HALF(8), .TIMEOUT(200)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn_select(btn_select), .btn_inc(btn_inc),
    .set_mode(set_mode), .sel_field(sel_field), .inc_hour(inc_hour), .inc_min(inc_min),
    .inc_sec(inc_sec), .blink(blink), .mode_at(mode_at)
  );

  // One clock; also checks that pulses are exclusive and absent outside SET states.
  task automatic step();
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    total++;
    if (((int'(inc_hour) + int'(inc_min) + int'(inc_sec)) > 1) ||
        ((set_mode !== 1'b1) && ((inc_hour | inc_min | inc_sec) !== 1'b0))) begin
      bad++;
      $display("FAIL inc_exclusive got h=%b m=%b s=%b set_mode=%b want <=1 pulse and none in RUN",
               inc_hour, inc_min, inc_sec, set_mode);
    end
  endtask

  task automatic press_select();
    btn_select = 1'b1;
    repeat (10) step();
    btn_select = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_100MHz);
    total++; if (set_mode !== 1'b0) begin bad++; $display("FAIL rst_set_mode got=%b want=0", set_mode); end
    total++; if (sel_field !== 2'b00) begin bad++; $display("FAIL rst_sel_field got=%b want=00", sel_field); end
    total++; if (mode_at !== 4'hB) begin bad++; $display("FAIL rst_mode_at got=%h want=b", mode_at); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL rst_blink got=%b want=1", blink); end
    total++; if ({inc_hour, inc_min, inc_sec} !== 3'b000) begin bad++; $display("FAIL rst_inc got=%b want=000", {inc_hour, inc_min, inc_sec}); end
    reset = 1'b0;
    repeat (3) step();
    total++; if (sel_field !== 2'b00) begin bad++; $display("FAIL post_rst_sel got=%b want=00", sel_field); end
  endtask

  task automatic test_glitch_select();
    btn_select = 1'b1;
    repeat (3) step();
    btn_select = 1'b0;
    repeat (10) step();
    total++; if (sel_field !== 2'b00) begin bad++; $display("FAIL glitch_sel got=%b want=00", sel_field); end
    btn_select = 1'b1;
    repeat (6) step();
    total++; if (sel_field !== 2'b00) begin bad++; $display("FAIL clean_early got=%b want=00", sel_field); end
    step();
    total++; if (sel_field !== 2'b01) begin bad++; $display("FAIL clean_sel got=%b want=01", sel_field); end
    total++; if (mode_at !== 4'hC) begin bad++; $display("FAIL clean_mode_at got=%h want=c", mode_at); end
    total++; if (set_mode !== 1'b1) begin bad++; $display("FAIL clean_set_mode got=%b want=1", set_mode); end
    repeat (3) step();
    btn_select = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_inc_repeat();
    logic exp_p;
    press_select();
    total++; if (sel_field !== 2'b10) begin bad++; $display("FAIL rep_sel got=%b want=10", sel_field); end
    btn_inc = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      exp_p = (k == 7) || (k == 27) || (k == 32) || (k == 37) || (k == 42);
      total++; if (inc_min !== exp_p) begin bad++; $display("FAIL rep_inc_min k=%0d got=%b want=%b", k, inc_min, exp_p); end
      total++; if ((inc_hour | inc_sec) !== 1'b0) begin bad++; $display("FAIL rep_other k=%0d got h=%b s=%b want 0", k, inc_hour, inc_sec); end
      if (k == 15) begin total++; if (blink !== 1'b0) begin bad++; $display("FAIL rep_blink15 got=%b want=0", blink); end end
      if (k == 23) begin total++; if (blink !== 1'b1) begin bad++; $display("FAIL rep_blink23 got=%b want=1", blink); end end
      if (k == 40) btn_inc = 1'b0;
    end
  endtask

  task automatic test_select_cycle();
    logic [1:0] exp_sel [4];
    exp_sel = '{2'b01, 2'b10, 2'b11, 2'b00};
    press_select();
    total++; if (sel_field !== 2'b11) begin bad++; $display("FAIL cyc_sec got=%b want=11", sel_field); end
    press_select();
    total++; if (sel_field !== 2'b00) begin bad++; $display("FAIL cyc_run got=%b want=00", sel_field); end
    total++; if (set_mode !== 1'b0) begin bad++; $display("FAIL cyc_set_mode got=%b want=0", set_mode); end
    total++; if (mode_at !== 4'hB) begin bad++; $display("FAIL cyc_mode_at got=%h want=b", mode_at); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL cyc_blink got=%b want=1", blink); end
    btn_inc = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      total++; if ({inc_hour, inc_min, inc_sec} !== 3'b000) begin bad++; $display("FAIL run_inc k=%0d got=%b want=000", k, {inc_hour, inc_min, inc_sec}); end
      if (k == 30) btn_inc = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      press_select();
      total++; if (sel_field !== exp_sel[i]) begin bad++; $display("FAIL cyc4_sel i=%0d got=%b want=%b", i, sel_field, exp_sel[i]); end
      total++; if (set_mode !== (exp_sel[i] != 2'b00)) begin bad++; $display("FAIL cyc4_set_mode i=%0d got=%b", i, set_mode); end
    end
  endtask

  task automatic test_simultaneous();
    press_select();
    total++; if (sel_field !== 2'b01) begin bad++; $display("FAIL sim_start got=%b want=01", sel_field); end
    btn_select = 1'b1;
    btn_inc    = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 6) begin total++; if (sel_field !== 2'b01) begin bad++; $display("FAIL sim_early got=%b want=01", sel_field); end end
      if (k == 7) begin total++; if (sel_field !== 2'b10) begin bad++; $display("FAIL sim_sel got=%b want=10", sel_field); end end
      total++; if ({inc_hour, inc_min, inc_sec} !== 3'b000) begin bad++; $display("FAIL sim_inc k=%0d got=%b want=000", k, {inc_hour, inc_min, inc_sec}); end
      if (k == 10) begin btn_select = 1'b0; btn_inc = 1'b0; end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_p;
    btn_inc = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step();
      exp_p = (k == 7);
      total++; if (inc_min !== exp_p) begin bad++; $display("FAIL hold_inc_min k=%0d got=%b want=%b", k, inc_min, exp_p); end
      total++; if ((inc_hour | inc_sec) !== 1'b0) begin bad++; $display("FAIL hold_other k=%0d got h=%b s=%b want 0", k, inc_hour, inc_sec); end
      if (k == 16) begin total++; if (sel_field !== 2'b10) begin bad++; $display("FAIL hold_sel16 got=%b want=10", sel_field); end end
      if (k == 17) begin total++; if (sel_field !== 2'b11) begin bad++; $display("FAIL hold_sel17 got=%b want=11", sel_field); end end
      if (k == 10) btn_select = 1'b1;
      if (k == 20) btn_select = 1'b0;
      if (k == 60) btn_inc = 1'b0;
    end
    press_select();
    total++; if (sel_field !== 2'b00) begin bad++; $display("FAIL hold_end_run got=%b want=00", sel_field); end
  endtask

  task automatic test_timeout();
    logic exp_b;
    press_select();
    press_select();
    btn_select = 1'b1;
    for (int k = 1; k <= 215; k++) begin
      step();
      if (k == 10) btn_select = 1'b0;
      if (k == 6) begin total++; if (sel_field !== 2'b10) begin bad++; $display("FAIL to_pre got=%b want=10", sel_field); end end
      if ((k >= 7) && (k <= 207)) begin
        exp_b = (((k - 7) / 8) % 2) == 0;
        total++; if (sel_field !== 2'b11) begin bad++; $display("FAIL to_sel k=%0d got=%b want=11", k, sel_field); end
        total++; if (blink !== exp_b) begin bad++; $display("FAIL to_blink k=%0d got=%b want=%b", k, blink, exp_b); end
      end
      if (k == 208) begin
        total++; if (sel_field !== 2'b00) begin bad++; $display("FAIL to_run got=%b want=00", sel_field); end
        total++; if (set_mode !== 1'b0) begin bad++; $display("FAIL to_set_mode got=%b want=0", set_mode); end
        total++; if (blink !== 1'b1) begin bad++; $display("FAIL to_blink_run got=%b want=1", blink); end
        total++; if (mode_at !== 4'hB) begin bad++; $display("FAIL to_mode_at got=%h want=b", mode_at); end
      end
      if (k == 215) begin total++; if (sel_field !== 2'b00) begin bad++; $display("FAIL to_stay got=%b want=00", sel_field); end end
    end
  endtask

  task automatic test_reset_mid();
    press_select();
    repeat (5) step();
    total++; if (sel_field !== 2'b01) begin bad++; $display("FAIL rmid_pre got=%b want=01", sel_field); end
    @(posedge clk_100MHz);
    #3;
    reset = 1'b1;
    #1;
    total++; if (set_mode !== 1'b0) begin bad++; $display("FAIL rmid_set_mode got=%b want=0", set_mode); end
    total++; if (sel_field !== 2'b00) begin bad++; $display("FAIL rmid_sel got=%b want=00", sel_field); end
    total++; if (mode_at !== 4'hB) begin bad++; $display("FAIL rmid_mode_at got=%h want=b", mode_at); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL rmid_blink got=%b want=1", blink); end
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (5) step();
    total++; if (sel_field !== 2'b00) begin bad++; $display("FAIL rmid_after got=%b want=00", sel_field); end
  endtask

  initial begin
    test_reset();
    test_glitch_select();
    test_inc_repeat();
    test_select_cycle();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
